// File: rtl/riscv_alu_issue_pkg.sv
// Typed views of the shared RV32I constants plus the ID/EX register payload.
`include "riscv_configs.v"

package riscv_alu_issue_pkg;

   localparam int XLEN = `XLEN;

   localparam logic [6:0] OPC_OP     = `OPC_OP;
   localparam logic [6:0] OPC_OP_IMM = `OPC_OP_IMM;
   localparam logic [6:0] OPC_LUI    = `OPC_LUI;
   localparam logic [6:0] OPC_AUIPC  = `OPC_AUIPC;

   localparam logic [3:0] ALU_CTRL_ADD  = `ALU_CTRL_ADD;
   localparam logic [3:0] ALU_CTRL_SUB  = `ALU_CTRL_SUB;
   localparam logic [3:0] ALU_CTRL_SLL  = `ALU_CTRL_SLL;
   localparam logic [3:0] ALU_CTRL_SLT  = `ALU_CTRL_SLT;
   localparam logic [3:0] ALU_CTRL_SLTU = `ALU_CTRL_SLTU;
   localparam logic [3:0] ALU_CTRL_XOR  = `ALU_CTRL_XOR;
   localparam logic [3:0] ALU_CTRL_SRL  = `ALU_CTRL_SRL;
   localparam logic [3:0] ALU_CTRL_SRA  = `ALU_CTRL_SRA;
   localparam logic [3:0] ALU_CTRL_OR   = `ALU_CTRL_OR;
   localparam logic [3:0] ALU_CTRL_AND  = `ALU_CTRL_AND;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [3:0]      ctrl;
      logic [4:0]      rd;
      logic            we;
      logic            ill;
   } issue_t;

   localparam issue_t ISSUE_RST = '{a: '0, b: '0, ctrl: ALU_CTRL_ADD, rd: '0, we: 1'b0, ill: 1'b0};

   // funct7=0 mapping shared by OP and OP-IMM
   function automatic logic [3:0] f3_ctrl(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_CTRL_ADD;
         3'b001:  return ALU_CTRL_SLL;
         3'b010:  return ALU_CTRL_SLT;
         3'b011:  return ALU_CTRL_SLTU;
         3'b100:  return ALU_CTRL_XOR;
         3'b101:  return ALU_CTRL_SRL;
         3'b110:  return ALU_CTRL_OR;
         default: return ALU_CTRL_AND;
      endcase
   endfunction

endpackage

// File: rtl/riscv_alu_issue_if.sv
// Decode-to-execute handshake and operand bus; slave is the issue register's view.
interface riscv_alu_issue_if;
   import riscv_alu_issue_pkg::*;

   logic            i_valid;
   logic            o_ready;
   logic [31:0]     i_instr;
   logic [XLEN-1:0] i_pc;
   logic [XLEN-1:0] i_rs1_data;
   logic [XLEN-1:0] i_rs2_data;
   logic            i_flush;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_alu_a;
   logic [XLEN-1:0] o_alu_b;
   logic [3:0]      o_alu_ctrl;
   logic [4:0]      o_rd_addr;
   logic            o_rd_we;
   logic            o_illegal;

   modport slave (
      input  i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_flush, i_ready,
      output o_ready, o_valid, o_alu_a, o_alu_b, o_alu_ctrl, o_rd_addr, o_rd_we, o_illegal
   );

   modport master (
      output i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_flush, i_ready,
      input  o_ready, o_valid, o_alu_a, o_alu_b, o_alu_ctrl, o_rd_addr, o_rd_we, o_illegal
   );
endinterface

// File: rtl/riscv_alu_dec.sv
// Combinational RV32I ALU-path decode: operand select, ALU control, writeback enable, legality.
module riscv_alu_dec
   import riscv_alu_issue_pkg::*;
(
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic [XLEN-1:0] a_o,
   output logic [XLEN-1:0] b_o,
   output logic [3:0]      ctrl_o,
   output logic            we_o,
   output logic            illegal_o
);

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;

   assign opc   = instr_i[6:0];
   assign f3    = instr_i[14:12];
   assign f7    = instr_i[31:25];
   assign imm_i = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
   assign imm_u = {instr_i[31:12], 12'b0};

   always_comb begin
      illegal_o = 1'b1;
      ctrl_o    = ALU_CTRL_ADD;
      a_o       = rs1_i;
      b_o       = rs2_i;
      case (opc)
         OPC_OP: begin
            if (f7 == 7'b0000000) begin
               illegal_o = 1'b0;
               ctrl_o    = f3_ctrl(f3);
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
               illegal_o = 1'b0;
               ctrl_o    = ALU_CTRL_SUB;
            end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
               illegal_o = 1'b0;
               ctrl_o    = ALU_CTRL_SRA;
            end
         end
         OPC_OP_IMM: begin
            illegal_o = 1'b0;
            ctrl_o    = f3_ctrl(f3);
            b_o       = imm_i;
            // shifts reuse imm[11:5] as a funct7 qualifier
            if (f3 == 3'b001 && f7 != 7'b0000000) illegal_o = 1'b1;
            if (f3 == 3'b101) begin
               if (f7 == 7'b0100000)      ctrl_o    = ALU_CTRL_SRA;
               else if (f7 != 7'b0000000) illegal_o = 1'b1;
            end
         end
         OPC_LUI: begin
            illegal_o = 1'b0;
            a_o       = '0;
            b_o       = imm_u;
         end
         OPC_AUIPC: begin
            illegal_o = 1'b0;
            a_o       = pc_i;
            b_o       = imm_u;
         end
         default: ;
      endcase
      // illegal words carry a fixed, harmless payload downstream
      if (illegal_o) begin
         ctrl_o = ALU_CTRL_ADD;
         a_o    = rs1_i;
         b_o    = rs2_i;
      end
   end

   assign we_o = !illegal_o && (instr_i[11:7] != 5'd0);

endmodule

// File: rtl/riscv_configs.v
// Shared RV32I configuration: operand width, ALU-path opcodes and ALU control encodings.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V

`define XLEN 32

`define OPC_OP     7'b0110011
`define OPC_OP_IMM 7'b0010011
`define OPC_LUI    7'b0110111
`define OPC_AUIPC  7'b0010111

`define ALU_CTRL_ADD  4'd0
`define ALU_CTRL_SUB  4'd1
`define ALU_CTRL_SLL  4'd2
`define ALU_CTRL_SLT  4'd3
`define ALU_CTRL_SLTU 4'd4
`define ALU_CTRL_XOR  4'd5
`define ALU_CTRL_SRL  4'd6
`define ALU_CTRL_SRA  4'd7
`define ALU_CTRL_OR   4'd8
`define ALU_CTRL_AND  4'd9

`endif

// File: rtl/riscv_alu_issue.sv
// Single-entry ID/EX issue register with valid/ready handshake, flush and sync reset.
module riscv_alu_issue
   import riscv_alu_issue_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   riscv_alu_issue_if.slave   bus
);

   issue_t          dec_d;
   issue_t          out_q;
   logic            valid_q, valid_d;
   logic            load;
   logic [XLEN-1:0] dec_a, dec_b;
   logic [3:0]      dec_ctrl;
   logic            dec_we, dec_ill;

   riscv_alu_dec u_dec (
      .instr_i   (bus.i_instr),
      .pc_i      (bus.i_pc),
      .rs1_i     (bus.i_rs1_data),
      .rs2_i     (bus.i_rs2_data),
      .a_o       (dec_a),
      .b_o       (dec_b),
      .ctrl_o    (dec_ctrl),
      .we_o      (dec_we),
      .illegal_o (dec_ill)
   );

   always_comb begin
      dec_d = '{a: dec_a, b: dec_b, ctrl: dec_ctrl, rd: bus.i_instr[11:7], we: dec_we, ill: dec_ill};
   end

   // reset forces ready so upstream never stalls on a register about to be cleared
   assign bus.o_ready = i_rst || !valid_q || bus.i_ready;
   assign load        = bus.i_valid && bus.o_ready && !bus.i_flush;

   always_comb begin
      valid_d = valid_q;
      if (bus.i_flush)       valid_d = 1'b0;
      else if (load)         valid_d = 1'b1;
      else if (bus.i_ready)  valid_d = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         out_q   <= ISSUE_RST;
      end else begin
         valid_q <= valid_d;
         if (load) out_q <= dec_d;
      end
   end

   assign bus.o_valid    = valid_q;
   assign bus.o_alu_a    = out_q.a;
   assign bus.o_alu_b    = out_q.b;
   assign bus.o_alu_ctrl = out_q.ctrl;
   assign bus.o_rd_addr  = out_q.rd;
   assign bus.o_rd_we    = out_q.we;
   assign bus.o_illegal  = out_q.ill;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Directed bench for riscv_alu_issue: handshake model plus scoreboard of expected payloads.
module tb_riscv_alu_issue;
   import riscv_alu_issue_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   riscv_alu_issue_if bus ();

   riscv_alu_issue dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   logic mvalid = 1'b0;
   int   n_vec  = 0;
   int   n_bad  = 0;

   function automatic exp_t ex(input logic [31:0] a, b, input logic [3:0] c,
                               input logic [4:0] rd, input logic we, ill);
      exp_t e;
      e = '{a: a, b: b, ctrl: c, rd: rd, we: we, ill: ill};
      return e;
   endfunction

   function automatic exp_t cur();
      exp_t e;
      e = '{a: bus.o_alu_a, b: bus.o_alu_b, ctrl: bus.o_alu_ctrl, rd: bus.o_rd_addr,
            we: bus.o_rd_we, ill: bus.o_illegal};
      return e;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle: sample against the model at negedge, update model, advance past the edge.
   task automatic tick(input string tag, input exp_t e);
      logic rdy, ld;
      @(negedge clk);
      rdy = rst || !mvalid || bus.i_ready;
      chk({tag, ".o_ready"}, 128'(bus.o_ready), 128'(rdy));
      chk({tag, ".o_valid"}, 128'(bus.o_valid), 128'(mvalid));
      if (mvalid && sb.size() > 0) chk({tag, ".data"}, 128'(cur()), 128'(sb[0]));
      ld = bus.i_valid && rdy && !bus.i_flush && !rst;
      if (rst || bus.i_flush) begin
         sb.delete();
         mvalid = 1'b0;
      end else begin
         if (mvalid && bus.i_ready) void'(sb.pop_front());
         if (ld) sb.push_back(e);
         mvalid = ld ? 1'b1 : (bus.i_ready ? 1'b0 : mvalid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input string tag, input logic [31:0] ins, pc, r1, r2,
                      input logic v, rdy, input exp_t e);
      bus.i_instr    = ins;
      bus.i_pc       = pc;
      bus.i_rs1_data = r1;
      bus.i_rs2_data = r2;
      bus.i_valid    = v;
      bus.i_ready    = rdy;
      tick(tag, e);
   endtask

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_LUI  = 32'h12345337;
   localparam exp_t        E_RST  = '{a: '0, b: '0, ctrl: 4'd0, rd: '0, we: 1'b0, ill: 1'b0};

   initial begin
      bus.i_valid = 1'b0; bus.i_instr = '0; bus.i_pc = '0; bus.i_rs1_data = '0;
      bus.i_rs2_data = '0; bus.i_flush = 1'b0; bus.i_ready = 1'b0;

      // reset, with a load attempt that must be discarded
      drv("rst0", 32'h0, 0, 0, 0, 1'b0, 1'b0, '0);
      drv("rst1", I_ADD, 0, 5, 7, 1'b1, 1'b0, '0);
      rst = 1'b0;
      chk("rst_state", 128'(cur()), 128'(E_RST));

      // back-to-back legal and illegal decodes
      drv("add",   I_ADD,        0,     5,            7,     1, 1, ex(5, 7, ALU_CTRL_ADD, 3, 1, 0));
      drv("addi",  32'hFFF00213, 0,     0,            32'h55, 1, 1, ex(0, 32'hFFFFFFFF, ALU_CTRL_ADD, 4, 1, 0));
      drv("srai",  32'h4032D293, 0,     32'h80000000, 0,     1, 1, ex(32'h80000000, 32'h403, ALU_CTRL_SRA, 5, 1, 0));
      drv("srli",  32'h0032D293, 0,     32'h9,        0,     1, 1, ex(32'h9, 32'h3, ALU_CTRL_SRL, 5, 1, 0));
      drv("lui",   I_LUI,        0,     32'h11,       32'h22, 1, 1, ex(0, 32'h12345000, ALU_CTRL_ADD, 6, 1, 0));
      drv("auipc", 32'h00001397, 32'h100, 32'h33,     32'h44, 1, 1, ex(32'h100, 32'h1000, ALU_CTRL_ADD, 7, 1, 0));
      drv("sub",   32'h402081B3, 0,     9,            4,     1, 1, ex(9, 4, ALU_CTRL_SUB, 3, 1, 0));
      drv("sltu",  32'h0020B1B3, 0,     1,            2,     1, 1, ex(1, 2, ALU_CTRL_SLTU, 3, 1, 0));
      drv("ill_op",32'h4020F1B3, 0,     32'hA,        32'hB, 1, 1, ex(32'hA, 32'hB, ALU_CTRL_ADD, 3, 0, 1));
      drv("ill_sl",32'h40109193, 0,     32'hC,        32'hD, 1, 1, ex(32'hC, 32'hD, ALU_CTRL_ADD, 3, 0, 1));
      drv("ill_lw",32'h0000A183, 0,     32'hE,        32'hF, 1, 1, ex(32'hE, 32'hF, ALU_CTRL_ADD, 3, 0, 1));
      drv("add_x0",32'h00208033, 0,     1,            2,     1, 1, ex(1, 2, ALU_CTRL_ADD, 0, 0, 0));
      drv("drain", 32'h0,        0,     0,            0,     0, 1, '0);

      // stall three cycles with a new instruction waiting, then release
      drv("st_ld", I_ADD, 0, 5, 7, 1, 0, ex(5, 7, ALU_CTRL_ADD, 3, 1, 0));
      for (int i = 0; i < 3; i++)
         drv("stall", I_LUI, 0, 0, 0, 1, 0, ex(0, 32'h12345000, ALU_CTRL_ADD, 6, 1, 0));
      drv("st_rel", I_LUI, 0, 0, 0, 1, 1, ex(0, 32'h12345000, ALU_CTRL_ADD, 6, 1, 0));
      drv("st_out", 32'h0, 0, 0, 0, 0, 1, '0);

      // flush beats a simultaneous load
      bus.i_flush = 1'b1;
      drv("fl_ld", I_ADD, 0, 5, 7, 1, 1, ex(5, 7, ALU_CTRL_ADD, 3, 1, 0));
      bus.i_flush = 1'b0;
      drv("fl_chk", 32'h0, 0, 0, 0, 0, 1, '0);

      // flush of a held instruction
      drv("flh_ld", I_ADD, 0, 1, 1, 1, 0, ex(1, 1, ALU_CTRL_ADD, 3, 1, 0));
      bus.i_flush = 1'b1;
      drv("flh", I_LUI, 0, 0, 0, 1, 0, ex(0, 32'h12345000, ALU_CTRL_ADD, 6, 1, 0));
      bus.i_flush = 1'b0;
      drv("flh_chk", 32'h0, 0, 0, 0, 0, 0, '0);

      // reset in the middle of a stall drops the held instruction
      drv("rs_ld", 32'h0020B1B3, 0, 32'h77, 32'h88, 1, 0, ex(32'h77, 32'h88, ALU_CTRL_SLTU, 3, 1, 0));
      drv("rs_st", I_LUI, 0, 0, 0, 1, 0, ex(0, 32'h12345000, ALU_CTRL_ADD, 6, 1, 0));
      rst = 1'b1;
      drv("rs_rst", I_LUI, 0, 0, 0, 1, 0, ex(0, 32'h12345000, ALU_CTRL_ADD, 6, 1, 0));
      rst = 1'b0;
      chk("rs_state", 128'(cur()), 128'(E_RST));
      drv("rs_idle", 32'h0, 0, 0, 0, 0, 1, '0);

      chk("sb_empty", 128'(sb.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/riscv_alu_issue.md
RISCV_ALU_ISSUE -- requirements
Module: riscv_alu_issue

Interface
REQ-001 Parameter: none; operand width SHALL be the shared `XLEN macro (32 for RV32I).
REQ-002 Clock and reset SHALL be one clock, with a synchronous, active-high reset.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  synchronous active-high reset.
REQ-005 i_valid  input  1  decode-stage instruction valid.
REQ-006 o_ready  output  1  block can accept an instruction this cycle.
REQ-007 i_instr  input  32  RV32I instruction word.
REQ-008 i_pc  input  XLEN  PC of i_instr.
REQ-009 i_rs1_data, i_rs2_data  input  XLEN each  register-file read data.
REQ-010 i_flush  input  1  kill the held instruction (branch/trap redirect).
REQ-011 o_valid  output  1  execute-stage operands valid.
REQ-012 i_ready  input  1  execute stage consumes this cycle.
REQ-013 o_alu_a, o_alu_b  output  XLEN each  ALU operands.
REQ-014 o_alu_ctrl  output  4  ALU operation, encoded with the ALU_CTRL_* macros.
REQ-015 o_rd_addr  output  5  destination register.
REQ-016 o_rd_we  output  1  writeback enable.
REQ-017 o_illegal  output  1  instruction not executable by the ALU path.

Function
REQ-018 The block SHALL be a single-entry ID/EX register: o_ready = !o_valid || i_ready.
REQ-019 Load condition: i_valid && o_ready. On the next edge, all outputs SHALL take the decoded values and o_valid SHALL become 1. Latency is 1 cycle.
REQ-020 If o_valid && i_ready && !load, o_valid SHALL clear. Data outputs SHALL hold their last values.
REQ-021 If o_valid && !i_ready, all outputs SHALL hold unchanged. This holds regardless of i_valid.
REQ-022 i_flush SHALL clear o_valid on the next edge and suppress a simultaneous load. Flush has priority over load; reset has priority over flush.
REQ-023 OP (0110011), funct7=0000000: funct3 000/001/010/011/100/101/110/111 SHALL map to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
REQ-024 OP, funct7=0100000: funct3 000 SHALL map to SUB and 101 to SRA. Any other funct3, or any other funct7, SHALL be illegal.
REQ-025 OP operands: a=rs1, b=rs2.
REQ-026 OP-IMM (0010011) operands: a=rs1, b=sign-extended instr[31:20]. ADDI/SLTI/SLTIU/XORI/ORI/ANDI SHALL use the OP mapping.
REQ-027 SLLI requires instr[31:25]=0000000. SRLI/SRAI require instr[31:25]=0000000/0100000 respectively. Any other value SHALL be illegal.
REQ-028 LUI (0110111): a=0, b={instr[31:12],12'b0}, ctrl=ADD.
REQ-029 AUIPC (0010111): a=i_pc, b={instr[31:12],12'b0}, ctrl=ADD.
REQ-030 Any other opcode SHALL be illegal.
REQ-031 For illegal instructions: o_illegal=1, ctrl=ADD, o_rd_we=0, operands don't-care but deterministic (a=rs1, b=rs2).
REQ-032 o_rd_we SHALL be 1 only for legal instructions with rd≠0. o_rd_addr SHALL always equal instr[11:7].
REQ-033 Operand arithmetic SHALL be exact XLEN width; immediate sign-extension SHALL come from instr[31].

Reset
REQ-034 On i_rst, the block SHALL set o_valid=0, o_alu_a=0, o_alu_b=0, o_alu_ctrl=ALU_CTRL_ADD, o_rd_addr=0, o_rd_we=0, o_illegal=0.
REQ-035 While i_rst=1, o_ready SHALL be 1, and a load attempted in that cycle SHALL be discarded.
REQ-036 Reset mid-stall SHALL drop the held instruction.

Structure
REQ-037 The opcode constants (OP, OP_IMM, LUI, AUIPC) and the ALU_CTRL_* encodings SHALL reside in the shared riscv_configs.v.
REQ-038 Decode SHALL be a combinational sub-module riscv_alu_dec (instr, pc, rs1, rs2 -> a, b, ctrl, we, illegal). The top level SHALL hold only the handshake and pipeline register.

Verification
REQ-039 Load: ADD x3,x1,x2, rs1=5, rs2=7, i_ready=1 -> next cycle o_valid=1, a=5, b=7, ctrl=ADD, rd=3, we=1.
REQ-040 Immediate: ADDI x4,x0,-1 (0xFFF00213) -> b=0xFFFFFFFF, ctrl=ADD. SRAI x5,x5,3 -> ctrl=SRA, b[4:0]=3. LUI x6,0x12345 -> a=0, b=0x12345000.
REQ-041 AUIPC x7,1 at pc=0x100 -> a=0x100, b=0x1000, ctrl=ADD.
REQ-042 Illegal: funct7=0100000 with funct3=111 on OP, SLLI with imm[11:5]=0100000, opcode 0000011 -> o_illegal=1, we=0. ADD x0 -> we=0.
REQ-043 Stall: i_ready=0 for 3 cycles with new i_valid -> outputs frozen, o_ready=0. After i_ready=1, the next instruction SHALL load on that edge.
REQ-044 Flush with simultaneous i_valid and i_ready=1 -> o_valid=0 next cycle. Asserting i_rst during a stall -> all outputs at reset values next cycle.
